// File: rtl/fifo_out_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_out_packer_if
// Purpose  : Host-side stream of packed spectral words (master = packer).
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_out_packer_if #(
  parameter int BIT_WIDTH = 14
);
  logic [2*BIT_WIDTH-1:0] data_out;
  logic                   data_out_valid;
  logic                   out_last;
  logic                   out_ready;

  modport master (
    output data_out,
    output data_out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    input  out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/fifo_out_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_out_packer
// Purpose  : Keeps the one-sided half of each FFT range bin, packs sample
//            pairs into 2*BIT_WIDTH words and buffers them in a FWFT FIFO.
//            Optional per-bin header words: define FIFO_OUT_HEADER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_out_packer #(
  parameter int BIT_WIDTH = 14,
  parameter int NFFT      = 1024,
  parameter int DEPTH     = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4:0]           nBins,
  input  logic [BIT_WIDTH-1:0] data_in,
  input  logic                 data_in_valid,
  output logic                 busy,
  output logic                 overflow,
  fifo_out_packer_if.master    out_bus
);

  localparam int WW = 2 * BIT_WIDTH;
  localparam int PW = $clog2(NFFT);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [PW-1:0] P_LAST      = PW'(NFFT - 1);
  localparam logic [PW-1:0] P_HALF_LAST = PW'(NFFT / 2 - 1);
  localparam logic [CW-1:0] C_FULL      = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        p_q, p_d;
  logic [4:0]           bin_q, bin_d;
  logic [4:0]           nbins_q, nbins_d;
  logic [BIT_WIDTH-1:0] even_q, even_d;
  logic                 overflow_q, overflow_d;
  logic                 busy_q, busy_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WW-1:0]        dout_q, dout_d;
  logic                 dvalid_q, dvalid_d;
  logic                 dlast_q, dlast_d;

  // Entry = {last flag, packed word}.
  logic [WW:0]          buf_mem [DEPTH];

  logic                 wr_req;
  logic [WW:0]          wr_word;
  logic                 wr_acc;
  logic                 pop;
  logic                 full;
  logic                 mem_empty;
  logic                 bypass;
  logic                 mem_we;
  logic                 last_bin;

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    bin_d      = bin_q;
    nbins_d    = nbins_q;
    even_d     = even_q;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    dvalid_d   = dvalid_q;
    dlast_d    = dlast_q;
    wr_req     = 1'b0;
    wr_word    = '0;
    last_bin   = (bin_q == (nbins_q - 5'd1));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = COLLECT;
          p_d        = '0;
          bin_d      = '0;
          even_d     = '0;
          overflow_d = 1'b0;
          nbins_d    = (nBins == 5'd0) ? 5'd1 : nBins;
        end
      end
      COLLECT: begin
        if (data_in_valid) begin
          p_d = (p_q == P_LAST) ? '0 : p_q + PW'(1);
          // Upper half of the spectrum (MSB of p set) is the mirror image and is dropped.
          if (!p_q[PW-1]) begin
            if (!p_q[0]) begin
              even_d = data_in;
            end else begin
              wr_req  = 1'b1;
              wr_word = {last_bin && (p_q == P_HALF_LAST), data_in, even_q};
            end
          end
`ifdef FIFO_OUT_HEADER_EN
          if (p_q == '0) begin
            wr_req  = 1'b1;
            wr_word = {1'b0, {(WW-8){1'b0}}, 4'hA, bin_q[3:0]};
          end
`endif
          if (p_q == P_LAST) begin
            bin_d = bin_q + 5'd1;
            if (last_bin) begin
              state_d = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (count_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // count_q includes the word held in the output register.
    pop       = dvalid_q && out_bus.out_ready;
    full      = (count_q == C_FULL);
    wr_acc    = wr_req && (!full || pop);
    mem_empty = (wr_ptr_q == rd_ptr_q);
    bypass    = (!dvalid_q || pop) && mem_empty && wr_acc;
    mem_we    = wr_acc && !bypass;

    if (wr_req && !wr_acc) begin
      overflow_d = 1'b1;
    end

    if (!dvalid_q || pop) begin
      if (!mem_empty) begin
        {dlast_d, dout_d} = buf_mem[rd_ptr_q];
        dvalid_d          = 1'b1;
        rd_ptr_d          = rd_ptr_q + AW'(1);
      end else if (wr_acc) begin
        {dlast_d, dout_d} = wr_word;
        dvalid_d          = 1'b1;
      end else begin
        dvalid_d          = 1'b0;
      end
    end

    if (mem_we) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    count_d = count_q + CW'(wr_acc) - CW'(pop);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      p_q        <= '0;
      bin_q      <= '0;
      nbins_q    <= 5'd1;
      even_q     <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      dvalid_q   <= 1'b0;
      dlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      bin_q      <= bin_d;
      nbins_q    <= nbins_d;
      even_q     <= even_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
      dlast_q    <= dlast_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      buf_mem[wr_ptr_q] <= wr_word;
    end
  end

  assign out_bus.data_out       = dout_q;
  assign out_bus.data_out_valid = dvalid_q;
  assign out_bus.out_last       = dlast_q;
  assign busy                   = busy_q;
  assign overflow               = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_out_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_out_packer
// Purpose  : Randomized bench; expected word stream is rebuilt from the
//            recorded samples (pairs of the lower half of each bin).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_out_packer;

  localparam int BW    = 14;
  localparam int NFFT  = 1024;
  localparam int DEPTH = 512;
  localparam int WPB   = NFFT / 4;
`ifdef FIFO_OUT_HEADER_EN
  localparam int HDR   = 1;
`else
  localparam int HDR   = 0;
`endif

  typedef logic [2*BW:0] word_t;

  logic          clk           = 1'b0;
  logic          rst           = 1'b1;
  logic          start         = 1'b0;
  logic          data_in_valid = 1'b0;
  logic [4:0]    nBins         = 5'd0;
  logic [BW-1:0] data_in       = '0;
  logic          busy;
  logic          overflow;

  fifo_out_packer_if #(.BIT_WIDTH(BW)) bus ();

  fifo_out_packer #(
    .BIT_WIDTH (BW),
    .NFFT      (NFFT),
    .DEPTH     (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .nBins         (nBins),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .busy          (busy),
    .overflow      (overflow),
    .out_bus       (bus)
  );

  always #5 clk = ~clk;

  int            n_checks  = 0;
  int            n_errors  = 0;
  int            hold_viol = 0;
  int            rdy_mode  = 1;
  word_t         got_q[$];
  word_t         exp_q[$];
  logic [BW-1:0] smp_q[$];
  logic          prev_hold = 1'b0;
  word_t         prev_word = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Host-side observer: records accepted words and watches hold-while-stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && (!bus.data_out_valid || {bus.out_last, bus.data_out} !== prev_word))
        hold_viol++;
      if (bus.data_out_valid && bus.out_ready)
        got_q.push_back({bus.out_last, bus.data_out});
      prev_hold = bus.data_out_valid && !bus.out_ready;
      prev_word = {bus.out_last, bus.data_out};
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        2:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: bin b yields an optional header then words {s[2k+1], s[2k]} for k < NFFT/4.
  function automatic void build_expected(input int nb_eff);
    for (int b = 0; b < nb_eff; b++) begin
      if (HDR != 0) exp_q.push_back(word_t'({4'hA, b[3:0]}));
      for (int k = 0; k < WPB; k++)
        exp_q.push_back({(b == nb_eff - 1) && (k == WPB - 1),
                         smp_q[b*NFFT + 2*k + 1], smp_q[b*NFFT + 2*k]});
    end
  endfunction

  task automatic send_frame(input int nb, input bit ramp, input int nsamp,
                            input int vprob, input bit stray_start);
    int sent = 0;
    smp_q.delete();
    repeat (3) begin
      data_in_valid = 1'b1;
      data_in       = BW'($urandom);
      step();
    end
    data_in_valid = 1'b0;
    start         = 1'b1;
    nBins         = nb[4:0];
    step();
    start         = 1'b0;
    check("busy_after_start", busy, 1);
    check("ovf_clear_on_start", overflow, 0);
    while (sent < nsamp) begin
      data_in_valid = ($urandom_range(0, 99) < vprob);
      if (data_in_valid) begin
        data_in = ramp ? BW'(sent % NFFT) : BW'($urandom);
        smp_q.push_back(data_in);
        sent++;
      end
      if (stray_start && sent == 500) begin
        start = 1'b1;
        nBins = 5'd7;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    repeat (4) begin
      data_in_valid = 1'b1;
      data_in       = BW'($urandom);
      step();
    end
    data_in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic compare_stream(input string tag);
    int nbad  = 0;
    int first = -1;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        nbad++;
        if (first < 0) first = i;
      end
    end
    check({tag, "_bad_words"}, nbad, 0);
    if (first >= 0) check({tag, "_first_bad"}, got_q[first], exp_q[first]);
  endtask

  task automatic clear_streams();
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit ovf_exp;
    int nb;
    int eff;

    repeat (3) @(negedge clk);
    check("rst_valid", bus.data_out_valid, 0);
    check("rst_data", bus.data_out, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    step();
    rst = 1'b0;
    step();

    // Ramp frame, one bin, host always ready.
    rdy_mode = 1;
    clear_streams();
    send_frame(1, 1'b1, NFFT, 100, 1'b0);
    build_expected(1);
    wait_idle("t1_idle", 100);
    compare_stream("t1");
    if (got_q.size() > WPB - 1 + HDR) begin
      check("t1_first", got_q[HDR], {1'b0, 14'd1, 14'd0});
      check("t1_last", got_q[WPB - 1 + HDR], {1'b1, 14'd511, 14'd510});
    end

    // Two bins into a stalled host: exactly fills the buffer.
    rdy_mode = 0;
    step();
    step();
    clear_streams();
    send_frame(2, 1'b0, 2 * NFFT, 100, 1'b0);
    build_expected(2);
    ovf_exp = (exp_q.size() > DEPTH);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    repeat (5) step();
    check("t2_ovf", overflow, ovf_exp);
    check("t2_busy_held", busy, 1);
    check("t2_valid", bus.data_out_valid, 1);
    check("t2_head", {bus.out_last, bus.data_out}, exp_q[0]);
    check("t2_none_taken", got_q.size(), 0);
    rdy_mode = 1;
    wait_idle("t2_idle", DEPTH + 100);
    compare_stream("t2");

    // Three bins into a stalled host: last bin is dropped.
    rdy_mode = 0;
    step();
    step();
    clear_streams();
    send_frame(3, 1'b1, 3 * NFFT, 100, 1'b0);
    build_expected(3);
    ovf_exp = (exp_q.size() > DEPTH);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    repeat (5) step();
    check("t3_ovf", overflow, ovf_exp);
    rdy_mode = 1;
    wait_idle("t3_idle", DEPTH + 100);
    compare_stream("t3");
    check("t3_ovf_sticky", overflow, 1);

    // Ready toggling every cycle, plus a stray start mid-frame.
    rdy_mode = 2;
    clear_streams();
    send_frame(2, 1'b0, 2 * NFFT, 100, 1'b1);
    build_expected(2);
    wait_idle("t4_idle", 2 * DEPTH + 100);
    compare_stream("t4");
`ifdef FIFO_OUT_HEADER_EN
    if (got_q.size() > WPB + 1) begin
      check("t4_hdr0", got_q[0], 29'h0A0);
      check("t4_hdr1", got_q[WPB + 1], 29'h0A1);
    end
`endif

    // Reset in the middle of a frame, then a fresh single-bin frame.
    rdy_mode = 1;
    send_frame(2, 1'b0, 300, 100, 1'b0);
    rst = 1'b1;
    step();
    check("t5_rst_valid", bus.data_out_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_data", bus.data_out, 0);
    check("t5_rst_ovf", overflow, 0);
    rst = 1'b0;
    step();
    clear_streams();
    send_frame(1, 1'b0, NFFT, 100, 1'b0);
    build_expected(1);
    wait_idle("t5_idle", 100);
    compare_stream("t5");

    // Randomized frames; first one uses nBins = 0.
    for (int f = 0; f < 4; f++) begin
      nb  = (f == 0) ? 0 : $urandom_range(1, 3);
      eff = (nb == 0) ? 1 : nb;
      rdy_mode = 3;
      clear_streams();
      send_frame(nb, 1'b0, eff * NFFT, $urandom_range(50, 100), 1'b0);
      build_expected(eff);
      wait_idle("rand_idle", 2000);
      compare_stream("rand");
      check("rand_ovf", overflow, 0);
    end

    check("hold_stable", hold_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
